mux_pair_sequencer: RTL and testbench
=====================================

// Module: mux_pair_sequencer
// PURPOSE
//  Self-checking stimulus/check stage for the two 4:1 MUX implementations (NAND-gate and notif1-tristate).
//  Drives shared data inputs a,b,c,d and selects s1,s0, and walks two data patterns through all four select codes.
//  After a settle dwell it samples both MUX outputs, compares each against the expected value and reports errors.
//  Sits upstream (feeds) and downstream (consumes) of the MUX pair; replaces hand-timed #50 stimulus.
// PARAMETERS
//  DWELL  4        settle cycles per select code before sampling (>=1)
//  PAT0   4'b1001  first data pattern {d,c,b,a}: a=1,b=0,c=0,d=1
//  PAT1   4'b1010  second data pattern {d,c,b,a}: a=0,b=1,c=0,d=1
//  CNT_W  8        width of mismatch counter
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      synchronous active-low reset
//  start          in   1      run request, sampled only in IDLE
//  y_nand         in   1      output of NAND-based MUX
//  y_notif        in   1      output of notif1-based MUX
//  a,b,c,d        out  1 ea   MUX data inputs
//  s1,s0          out  1 ea   MUX select, sel={s1,s0}; 0->a 1->b 2->c 3->d
//  busy           out  1      run in progress
//  done           out  1      one-cycle pulse, run complete
//  pass           out  1      last run had err_cnt==0 (valid once done has pulsed)
//  err_cnt        out  CNT_W  samples where either MUX mismatched, saturating
//  nand_err       out  1      sticky: y_nand mismatched at least once this run
//  notif_err      out  1      sticky: y_notif mismatched at least once this run
//  first_err      out  3      {pat_idx,s1,s0} of first mismatching sample
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; a..d=0; s1,s0=0; busy,done,pass,nand_err,notif_err=0; err_cnt=0; first_err=0.
//  Reset overrides everything, including mid-run; run is abandoned and no done pulse is issued.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//   IDLE: start=1 -> SETTLE. Same edge: load {d,c,b,a}=PAT0 and sel=00, set busy=1,
//         clear err_cnt, nand_err, notif_err, pass and first_err, and set pat_idx=0 and dwell counter=0.
//   SETTLE: outputs held; counter increments; after DWELL cycles in SETTLE -> SAMPLE.
//   SAMPLE: one cycle. exp = data[sel]. At the edge leaving SAMPLE:
//     - mismatch = (y_nand!=exp)|(y_notif!=exp); if mismatch, err_cnt+=1, saturating at 2^CNT_W-1.
//     - set nand_err/notif_err individually; the first mismatch of the run latches first_err.
//     - next sel in Gray order 00->01->11->10; after 10: if pat_idx=0, load PAT1, sel=00, pat_idx=1.
//     - after pat_idx=1,sel=10 -> DONE; otherwise -> SETTLE with counter=0.
//   DONE: one cycle; done=1, busy=0, pass=(err_cnt==0); then -> IDLE. start is ignored here.
//  Run length: first SAMPLE edge to final update = 8 samples; start edge to done high = 8*(DWELL+1) cycles.
//  Results (err_cnt, flags, first_err, pass) hold until the next accepted start or reset.
//  start while busy: ignored, no restart. start held high: new run begins in the cycle after DONE's IDLE.
//  Data/select outputs hold last pattern/sel after DONE until next start.
//  Outputs are registered; no combinational path from y_* to any output.
// TESTING
//  T1 ideal MUX models, DWELL=4, start pulse -> done high 40 cycles after start edge, err_cnt=0, pass=1.
//  T2 y_nand stuck at 0 -> err_cnt=4, nand_err=1, notif_err=0, first_err=3'b000, pass=0.
//  T3 y_notif inverted, CNT_W=2 -> 8 mismatches, err_cnt saturates at 3, first_err=3'b000.
//  T4 rst_n=0 during 5th SETTLE -> next cycle all outputs at reset values; no done pulse; subsequent start runs cleanly.
//  T5 start pulsed mid-run, then start held high -> mid-run pulse ignored; back-to-back runs, done every 42 cycles.
//  T6 y_nand wrong only at pattern1 sel=11 -> err_cnt=1, first_err=3'b111, s1,s0 sequence 00,01,11,10 twice.

Source files
------------

// File: rtl/mux_pair_sequencer.sv
// Stimulus/check sequencer for a pair of 4:1 MUX implementations: walks two data patterns
// through every select code, samples both MUX outputs after a settle dwell and tallies mismatches.
module mux_pair_sequencer #(
  parameter int unsigned DWELL = 4,
  parameter logic [3:0]  PAT0  = 4'b1001,
  parameter logic [3:0]  PAT1  = 4'b1010,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_nand,
  input  logic             y_notif,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             s1,
  output logic             s0,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             nand_err,
  output logic             notif_err,
  output logic [2:0]       first_err
);

  localparam int unsigned DwellW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic              pat_q, pat_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              nand_err_q, nand_err_d;
  logic              notif_err_q, notif_err_d;
  logic [2:0]        first_err_q, first_err_d;

  logic       exp_bit;
  logic       nand_mis;
  logic       notif_mis;
  logic [1:0] sel_next;

  always_comb begin
    exp_bit   = data_q[sel_q];
    nand_mis  = (y_nand != exp_bit);
    notif_mis = (y_notif != exp_bit);
  end

  // Gray walk keeps only one select line toggling per step.
  always_comb begin
    sel_next = 2'b00;
    unique case (sel_q)
      2'b00:   sel_next = 2'b01;
      2'b01:   sel_next = 2'b11;
      2'b11:   sel_next = 2'b10;
      default: sel_next = 2'b00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sel_d       = sel_q;
    pat_d       = pat_q;
    dwell_d     = dwell_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    nand_err_d  = nand_err_q;
    notif_err_d = notif_err_q;
    first_err_d = first_err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StSettle;
          data_d      = PAT0;
          sel_d       = 2'b00;
          pat_d       = 1'b0;
          dwell_d     = '0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_cnt_d   = '0;
          nand_err_d  = 1'b0;
          notif_err_d = 1'b0;
          first_err_d = 3'b000;
        end
      end

      StSettle: begin
        if (dwell_q == DwellLast) begin
          state_d = StSample;
        end else begin
          dwell_d = dwell_q + DwellW'(1);
        end
      end

      StSample: begin
        if (nand_mis || notif_mis) begin
          if (err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          // No sticky flag set yet means this is the run's first mismatch.
          if (!(nand_err_q || notif_err_q)) begin
            first_err_d = {pat_q, sel_q};
          end
        end
        nand_err_d  = nand_err_q | nand_mis;
        notif_err_d = notif_err_q | notif_mis;
        dwell_d     = '0;

        if (sel_q == 2'b10) begin
          if (pat_q) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end else begin
            state_d = StSettle;
            pat_d   = 1'b1;
            data_d  = PAT1;
            sel_d   = 2'b00;
          end
        end else begin
          state_d = StSettle;
          sel_d   = sel_next;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      data_q      <= 4'b0000;
      sel_q       <= 2'b00;
      pat_q       <= 1'b0;
      dwell_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      nand_err_q  <= 1'b0;
      notif_err_q <= 1'b0;
      first_err_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      pat_q       <= pat_d;
      dwell_q     <= dwell_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      nand_err_q  <= nand_err_d;
      notif_err_q <= notif_err_d;
      first_err_q <= first_err_d;
    end
  end

  assign {d, c, b, a} = data_q;
  assign {s1, s0}     = sel_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_cnt      = err_cnt_q;
  assign nand_err     = nand_err_q;
  assign notif_err    = notif_err_q;
  assign first_err    = first_err_q;

endmodule

// File: tb/tb_mux_pair_sequencer.sv
// Bench for mux_pair_sequencer: MUX models with injectable faults drive two instances
// (wide and 2-bit error counters); results are compared against a pattern-walk model.
module tb_mux_pair_sequencer;

  localparam int unsigned DWELL   = 4;
  localparam logic [3:0]  PAT0    = 4'b1001;
  localparam logic [3:0]  PAT1    = 4'b1010;
  localparam int          RUN_LAT = 8 * (DWELL + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic start;

  logic [7:0] nand_mask;
  logic [7:0] notif_mask;
  logic       nand_st0;

  logic       y_nand, y_notif, a, b, c, d, s1, s0, busy, done, pass, nand_err, notif_err;
  logic [7:0] err_cnt;
  logic [2:0] first_err;

  logic       y_nand_s, y_notif_s, a_s, b_s, c_s, d_s, s1_s, s0_s, busy_s, done_s, pass_s;
  logic       nand_err_s, notif_err_s;
  logic [1:0] err_cnt_s;
  logic [2:0] first_err_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Faults are keyed by {pattern, sel}, the same encoding first_err reports.
  function automatic logic mux_y(input logic [3:0] dv, input logic [1:0] sel,
                                 input logic [7:0] mask, input logic st0);
    logic [2:0] k;
    k = {(dv == PAT1), sel};
    return st0 ? 1'b0 : (dv[sel] ^ mask[k]);
  endfunction

  assign y_nand    = mux_y({d, c, b, a}, {s1, s0}, nand_mask, nand_st0);
  assign y_notif   = mux_y({d, c, b, a}, {s1, s0}, notif_mask, 1'b0);
  assign y_nand_s  = mux_y({d_s, c_s, b_s, a_s}, {s1_s, s0_s}, nand_mask, nand_st0);
  assign y_notif_s = mux_y({d_s, c_s, b_s, a_s}, {s1_s, s0_s}, notif_mask, 1'b0);

  mux_pair_sequencer #(.DWELL(DWELL), .PAT0(PAT0), .PAT1(PAT1), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_nand(y_nand), .y_notif(y_notif),
    .a(a), .b(b), .c(c), .d(d), .s1(s1), .s0(s0), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .nand_err(nand_err), .notif_err(notif_err), .first_err(first_err)
  );

  mux_pair_sequencer #(.DWELL(DWELL), .PAT0(PAT0), .PAT1(PAT1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .y_nand(y_nand_s), .y_notif(y_notif_s),
    .a(a_s), .b(b_s), .c(c_s), .d(d_s), .s1(s1_s), .s0(s0_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .err_cnt(err_cnt_s), .nand_err(nand_err_s), .notif_err(notif_err_s),
    .first_err(first_err_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: walk both patterns through the Gray select order and score each sample.
  function automatic void model(input logic [7:0] nm, input logic [7:0] tm, input logic st0,
                                output int cnt, output logic ne, output logic te,
                                output logic [2:0] fe);
    logic [3:0] pats [2];
    logic [1:0] sel;
    logic [2:0] k;
    logic       expv, yn, yt;
    pats[0] = PAT0;
    pats[1] = PAT1;
    cnt = 0;
    ne  = 1'b0;
    te  = 1'b0;
    fe  = 3'b000;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        sel  = 2'(i ^ (i >> 1));
        k    = {p[0], sel};
        expv = pats[p][sel];
        yn   = st0 ? 1'b0 : (expv ^ nm[k]);
        yt   = expv ^ tm[k];
        if (yn != expv || yt != expv) begin
          if (cnt == 0) fe = k;
          cnt++;
        end
        if (yn != expv) ne = 1'b1;
        if (yt != expv) te = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] exp_seq();
    logic [31:0] v;
    v = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        v = (v << 4) | 32'({1'b0, p[0], 2'(i ^ (i >> 1))});
      end
    end
    return v;
  endfunction

  // Called one step after a posedge with the DUT idle; returns one cycle after done.
  task automatic run_once(input string name, input logic [7:0] nm, input logic [7:0] tm,
                          input logic st0, input int pulse_at);
    int          lat;
    int          busy_low;
    logic [3:0]  key, prev;
    logic [3:0]  seq [$];
    logic [31:0] packed_seq;
    nand_mask  = nm;
    notif_mask = tm;
    nand_st0   = st0;
    start      = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_low = 0;
    prev     = 4'hf;
    while (!done && lat < 200) begin
      key = {({d, c, b, a} != PAT0 && {d, c, b, a} != PAT1), ({d, c, b, a} == PAT1), s1, s0};
      if (key != prev) begin
        seq.push_back(key);
        prev = key;
      end
      if (busy !== 1'b1) busy_low++;
      @(posedge clk); #1;
      lat++;
      start = (lat == pulse_at);
    end
    start = 1'b0;
    check({name, ".latency"}, 64'(lat), 64'(RUN_LAT));
    check({name, ".busy_during"}, 64'(busy_low), 64'd0);
    check({name, ".busy_at_done"}, 64'(busy), 64'd0);
    check({name, ".sat_done"}, 64'(done_s), 64'd1);
    packed_seq = '0;
    foreach (seq[i]) packed_seq = (packed_seq << 4) | 32'(seq[i]);
    check({name, ".sel_seq"}, {32'(seq.size()), packed_seq}, {32'd8, exp_seq()});
    @(posedge clk); #1;
    check({name, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic check_results(input string name, input int cnt, input logic ne,
                               input logic te, input logic [2:0] fe, input logic ps);
    check({name, ".err_cnt"}, 64'(err_cnt), 64'(cnt));
    check({name, ".err_cnt_sat"}, 64'(err_cnt_s), 64'((cnt > 3) ? 3 : cnt));
    check({name, ".nand_err"}, 64'(nand_err), 64'(ne));
    check({name, ".notif_err"}, 64'(notif_err), 64'(te));
    check({name, ".first_err"}, 64'(first_err), 64'(fe));
    check({name, ".pass"}, 64'(pass), 64'(ps));
    check({name, ".sat_first_err"}, 64'(first_err_s), 64'(fe));
  endtask

  typedef struct {
    string      name;
    logic [7:0] nm;
    logic [7:0] tm;
    logic       st0;
    int         cnt;
    logic       ne;
    logic       te;
    logic [2:0] fe;
    logic       ps;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int         cnt, done_cnt, lat;
    logic       ne, te;
    logic [2:0] fe;
    logic [7:0] nm, tm;
    logic       st0;
    int         pulse;
    int         dtimes [$];

    vecs[0] = '{"ideal",        8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0, 3'b000, 1'b1};
    vecs[1] = '{"nand_stuck0",  8'h00, 8'h00, 1'b1, 4, 1'b1, 1'b0, 3'b000, 1'b0};
    vecs[2] = '{"notif_inv",    8'h00, 8'hff, 1'b0, 8, 1'b0, 1'b1, 3'b000, 1'b0};
    vecs[3] = '{"nand_p1s11",   8'h80, 8'h00, 1'b0, 1, 1'b1, 1'b0, 3'b111, 1'b0};
    vecs[4] = '{"notif_p0s10",  8'h00, 8'h04, 1'b0, 1, 1'b0, 1'b1, 3'b010, 1'b0};
    vecs[5] = '{"mixed",        8'h40, 8'h02, 1'b0, 2, 1'b1, 1'b1, 3'b001, 1'b0};

    nand_mask  = 8'h00;
    notif_mask = 8'h00;
    nand_st0   = 1'b0;
    start      = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.outputs",
          64'({a, b, c, d, s1, s0, busy, done, pass, nand_err, notif_err, err_cnt, first_err}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_once(vecs[i].name, vecs[i].nm, vecs[i].tm, vecs[i].st0, -1);
      check_results(vecs[i].name, vecs[i].cnt, vecs[i].ne, vecs[i].te, vecs[i].fe, vecs[i].ps);
    end

    // Reset during the fifth settle, after faults have already been counted.
    nand_st0 = 1'b1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset.outputs",
          64'({a, b, c, d, s1, s0, busy, done, pass, nand_err, notif_err, err_cnt, first_err}), 64'd0);
    check("midreset.sat_outputs",
          64'({busy_s, done_s, pass_s, nand_err_s, notif_err_s, err_cnt_s, first_err_s}), 64'd0);
    rst_n    = 1'b1;
    done_cnt = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    check("midreset.no_done", 64'(done_cnt), 64'd0);
    run_once("after_reset", 8'h00, 8'h00, 1'b0, -1);
    check_results("after_reset", 0, 1'b0, 1'b0, 3'b000, 1'b1);

    // A start pulse mid-run must not restart, and nothing restarts afterwards.
    run_once("midpulse", 8'h00, 8'h00, 1'b0, 12);
    check_results("midpulse", 0, 1'b0, 1'b0, 3'b000, 1'b1);
    done_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy) done_cnt++;
    end
    check("midpulse.no_restart", 64'(done_cnt), 64'd0);

    // Start held high: back-to-back runs.
    start = 1'b1;
    for (int cyc = 1; cyc <= 130; cyc++) begin
      @(posedge clk); #1;
      if (done) dtimes.push_back(cyc);
    end
    start = 1'b0;
    check("held.count", 64'(dtimes.size()), 64'd3);
    if (dtimes.size() >= 3) begin
      check("held.first", 64'(dtimes[0]), 64'(RUN_LAT + 1));
      check("held.period1", 64'(dtimes[1] - dtimes[0]), 64'(RUN_LAT + 2));
      check("held.period2", 64'(dtimes[2] - dtimes[1]), 64'(RUN_LAT + 2));
    end
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("held.drain", 64'(done), 64'd1);
    @(posedge clk); #1;

    for (int r = 0; r < 12; r++) begin
      nm    = ($urandom_range(0, 2) == 0) ? 8'h00 : (8'($urandom) & 8'($urandom));
      tm    = ($urandom_range(0, 2) == 0) ? 8'h00 : (8'($urandom) & 8'($urandom));
      st0   = ($urandom_range(0, 5) == 0);
      pulse = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, RUN_LAT - 1));
      model(nm, tm, st0, cnt, ne, te, fe);
      run_once($sformatf("rnd%0d", r), nm, tm, st0, pulse);
      check_results($sformatf("rnd%0d", r), cnt, ne, te, fe, (cnt == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
